adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit carry look-ahead adder between two requesters, each with a valid/ready request channel and a valid/ready response channel.
- Uses round-robin grant and a 3-state FSM: accept operands, drive the adder, register the sum, hold the response until it is accepted.
- The adder sits outside this block and is combinational: add_in1/add_in2/add_c_in go in, add_sum/add_c_out come back.

Parameters:
- WIDTH, 16, operand and sum width (matches the 16-bit CLA).

Ports:
- clk, input, 1, system clock (rising edge).
- rst, input, 1, asynchronous active-high reset.
- reqN_valid, input, 1, requester N (N=0,1) presents operands.
- reqN_ready, output, 1, block accepts requester N's operands this cycle.
- reqN_in1, input, WIDTH, operand A from requester N.
- reqN_in2, input, WIDTH, operand B from requester N.
- reqN_c_in, input, 1, carry-in from requester N.
- rspN_valid, output, 1, result for requester N is available.
- rspN_ready, input, 1, requester N accepts the result.
- rspN_sum, output, WIDTH, registered sum for requester N.
- rspN_c_out, output, 1, registered carry-out for requester N.
- add_in1, output, WIDTH, operand A to the adder.
- add_in2, output, WIDTH, operand B to the adder.
- add_c_in, output, 1, carry-in to the adder.
- add_sum, input, WIDTH, sum from the adder.
- add_c_out, input, 1, carry-out from the adder.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - op_a, op_b, op_c, res_sum, res_c, grant all 0.
  - All outputs 0.
- Adder drive: add_in1=op_a, add_in2=op_b, add_c_in=op_c at all times.
- States: IDLE, ISSUE, RESP.
- IDLE, grant selection:
  - Only req0_valid -> grant 0. Only req1_valid -> grant 1.
  - Both valid -> grant the requester != last_grant.
  - reqN_ready=1 combinationally for the selected requester only, and only in IDLE.
- IDLE, handshake: on valid&&ready at the clock edge:
  - latch that requester's in1/in2/c_in into op_a/op_b/op_c;
  - grant<=N, last_grant<=N, go to ISSUE.
  - No valid -> stay in IDLE; op registers hold.
- ISSUE (exactly 1 cycle):
  - res_sum<=add_sum, res_c<=add_c_out; go to RESP.
  - Both reqN_ready are 0.
- RESP:
  - rsp[grant]_valid=1; the other rsp_valid=0; both req_ready=0.
  - rsp[grant]_ready=1 at the edge -> IDLE. Otherwise hold; res_sum/res_c are stable.
- rspN_sum/rspN_c_out are driven from res_sum/res_c when grant==N, else 0.
- Latency: accept edge T -> result registered at T+1 -> rsp_valid high from T+1 until accepted. Back-to-back throughput is one operation per 3 cycles minimum.
- Arithmetic: sum is modulo 2^WIDTH; c_out is the carry out of the MSB. The block performs no arithmetic itself.
- Boundary conditions:
  - Requester drops valid while not ready: no effect.
  - Requester changes operands after acceptance: no effect on the result.
  - rspN_ready asserted while rspN_valid=0: ignored.
  - A requester holding valid continuously cannot starve the other: grants strictly alternate when both are valid.
  - Reset during ISSUE/RESP: the transaction is dropped, no response is issued, and the block returns to reset values.
  - A new request in the same cycle as the response handshake is not accepted until the cycle after the FSM returns to IDLE.

Optional Feature:
- Macro: ADD_ARB_OVF_EN.
- Defined:
  - Adds outputs rsp0_ovf and rsp1_ovf (1 bit each).
  - ovf is registered in ISSUE as signed two's-complement overflow: (op_a[MSB]==op_b[MSB]) && (add_sum[MSB]!=op_a[MSB]).
  - Reset value 0; rspN_ovf is 0 when grant!=N; it is stable in RESP.
- Undefined: the ports and their register do not exist; all other behaviour is identical.

Test Plan:
- req0: 3245+16785, c_in=0 -> rsp0_valid one cycle after accept; rsp0_sum=20030, c_out=0.
- req1: 3245+16785, c_in=1 -> rsp1_sum=20031, c_out=0; rsp0_valid stays 0 throughout.
- req0: 25000+40535, c_in=0 -> sum=65535, c_out=0. Then req0: 25001+40535 -> sum=0, c_out=1. Then 25000+40535, c_in=1 -> sum=0, c_out=1.
- Both requesters valid continuously from reset, with distinct operands -> grant order 0,1,0,1; each response carries its own requester's sum; no double grant.
- Hold rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and rsp0_sum stay stable; req1_ready stays 0; completion follows when ready rises.
- Assert rst during ISSUE -> all outputs 0 immediately (asynchronous); no rsp_valid follows; next request completes normally. With ADD_ARB_OVF_EN: 16'h7FFF+16'h0001 -> ovf=1, sum=16'h8000.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// Request/response/adder bundle for adder_share_arbiter; slave is the arbiter side.
// The rsp0_ovf/rsp1_ovf signals exist only when ADD_ARB_OVF_EN is defined.
interface adder_share_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_in1;
    logic [WIDTH-1:0] req0_in2;
    logic             req0_c_in;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_in1;
    logic [WIDTH-1:0] req1_in2;
    logic             req1_c_in;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_sum;
    logic             rsp0_c_out;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_sum;
    logic             rsp1_c_out;

    logic [WIDTH-1:0] add_in1;
    logic [WIDTH-1:0] add_in2;
    logic             add_c_in;
    logic [WIDTH-1:0] add_sum;
    logic             add_c_out;

`ifdef ADD_ARB_OVF_EN
    logic             rsp0_ovf;
    logic             rsp1_ovf;
`endif

    modport slave (
`ifdef ADD_ARB_OVF_EN
        output rsp0_ovf, rsp1_ovf,
`endif
        input  req0_valid, req0_in1, req0_in2, req0_c_in,
        input  req1_valid, req1_in1, req1_in2, req1_c_in,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_sum, rsp0_c_out,
        output rsp1_valid, rsp1_sum, rsp1_c_out,
        input  rsp0_ready, rsp1_ready,
        output add_in1, add_in2, add_c_in,
        input  add_sum, add_c_out
    );

    modport master (
`ifdef ADD_ARB_OVF_EN
        input  rsp0_ovf, rsp1_ovf,
`endif
        output req0_valid, req0_in1, req0_in2, req0_c_in,
        output req1_valid, req1_in1, req1_in2, req1_c_in,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_sum, rsp0_c_out,
        input  rsp1_valid, rsp1_sum, rsp1_c_out,
        output rsp0_ready, rsp1_ready,
        input  add_in1, add_in2, add_c_in,
        output add_sum, add_c_out
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one external combinational adder between two requesters.
// Define ADD_ARB_OVF_EN to add registered signed-overflow flags to both responses.
module adder_share_arbiter #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    adder_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic             lastGrant_q, lastGrant_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             opC_q, opC_d;
    logic [WIDTH-1:0] resSum_q, resSum_d;
    logic             resC_q, resC_d;
`ifdef ADD_ARB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic anyValid;
    logic selGrant;

    // On a tie the requester that did not win last time is chosen, so neither can starve.
    always_comb begin
        anyValid = bus.req0_valid | bus.req1_valid;
        selGrant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            selGrant = ~lastGrant_q;
        end else if (bus.req1_valid) begin
            selGrant = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            grant_q     <= 1'b0;
            opA_q       <= '0;
            opB_q       <= '0;
            opC_q       <= 1'b0;
            resSum_q    <= '0;
            resC_q      <= 1'b0;
`ifdef ADD_ARB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            opC_q       <= opC_d;
            resSum_q    <= resSum_d;
            resC_q      <= resC_d;
`ifdef ADD_ARB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        opC_d       = opC_q;
        resSum_d    = resSum_q;
        resC_d      = resC_q;
`ifdef ADD_ARB_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    state_d     = ISSUE;
                    grant_d     = selGrant;
                    lastGrant_d = selGrant;
                    opA_d       = selGrant ? bus.req1_in1  : bus.req0_in1;
                    opB_d       = selGrant ? bus.req1_in2  : bus.req0_in2;
                    opC_d       = selGrant ? bus.req1_c_in : bus.req0_c_in;
                end
            end
            ISSUE: begin
                // The adder sees the latched operands for this whole cycle, so its output is settled.
                resSum_d = bus.add_sum;
                resC_d   = bus.add_c_out;
`ifdef ADD_ARB_OVF_EN
                ovf_d    = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                           (bus.add_sum[WIDTH-1] != opA_q[WIDTH-1]);
`endif
                state_d  = RESP;
            end
            RESP: begin
                if ((!grant_q && bus.rsp0_ready) || (grant_q && bus.rsp1_ready)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is masked by rst so every output reads 0 while reset is held.
    always_comb begin
        bus.add_in1    = opA_q;
        bus.add_in2    = opB_q;
        bus.add_c_in   = opC_q;
        bus.req0_ready = !rst && (state_q == IDLE) && bus.req0_valid && !selGrant;
        bus.req1_ready = !rst && (state_q == IDLE) && bus.req1_valid && selGrant;
        bus.rsp0_valid = (state_q == RESP) && !grant_q;
        bus.rsp1_valid = (state_q == RESP) && grant_q;
        bus.rsp0_sum   = grant_q ? '0 : resSum_q;
        bus.rsp1_sum   = grant_q ? resSum_q : '0;
        bus.rsp0_c_out = !grant_q && resC_q;
        bus.rsp1_c_out = grant_q && resC_q;
`ifdef ADD_ARB_OVF_EN
        bus.rsp0_ovf   = !grant_q && ovf_q;
        bus.rsp1_ovf   = grant_q && ovf_q;
`endif
    end

endmodule
